// File: rtl/neuron_lut_cfg_pkg.sv
// Shared types and sizing helpers for the runtime-programmable neuron LUT.
package neuron_lut_cfg_pkg;

  // Controller states, encoded exactly as exported on ctrl_state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    RUN   = 2'd3
  } ctrl_state_t;

  // Number of table entries addressed by an IN_BITS-wide neuron input.
  function automatic int lut_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

  // Width of one packed configuration beat.
  function automatic int cfg_width(input int pack, input int out_bits);
    return pack * out_bits;
  endfunction

endpackage

// File: rtl/neuron_lut_ram.sv
// Distributed-RAM truth table: PACK entries written per clock, combinational read.
module neuron_lut_ram
  import neuron_lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int PACK     = 4
) (
  input  logic                                 clk,
  input  logic                                 wr_en,
  input  logic [IN_BITS-1:0]                   wr_addr,
  input  logic [cfg_width(PACK, OUT_BITS)-1:0] wr_data,
  input  logic [IN_BITS-1:0]                   rd_addr,
  output logic [OUT_BITS-1:0]                  rd_data
);

  localparam int DEPTH = lut_depth(IN_BITS);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [OUT_BITS-1:0] mem [DEPTH];

  // Write one whole config beat into consecutive entries starting at wr_addr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < PACK; k++) begin
        mem[wr_addr + IN_BITS'(k)] <= wr_data[k*OUT_BITS +: OUT_BITS];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/neuron_lut_cfg_ctrl.sv
// Neuron truth-table controller: loads the LUT from a packed config stream and
// serves lookups through a one-deep valid/ready output register, never both at once.
module neuron_lut_cfg_ctrl
  import neuron_lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int PACK     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_start,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [cfg_width(PACK, OUT_BITS)-1:0] cfg_data,
  output logic                                 cfg_done,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [IN_BITS-1:0]                   in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_BITS-1:0]                  out_data,
  output logic [1:0]                           ctrl_state
);

  localparam int                 DEPTH     = lut_depth(IN_BITS);
  localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(DEPTH - PACK);
  localparam logic [IN_BITS-1:0] STEP      = IN_BITS'(PACK);

  if ((DEPTH % PACK) != 0) begin : g_pack_check
    $error("neuron_lut_cfg_ctrl: table depth must be a multiple of PACK");
  end

  ctrl_state_t         state, state_nxt;
  logic [IN_BITS-1:0]  wr_addr, wr_addr_nxt;
  logic                table_loaded, table_loaded_nxt;
  logic                cfg_done_nxt;
  logic                cfg_beat;
  logic                lookup;
  logic [OUT_BITS-1:0] rd_data;

  assign cfg_beat   = cfg_valid && cfg_ready;
  assign lookup     = in_valid && in_ready;
  assign ctrl_state = state;

  neuron_lut_ram #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .PACK    (PACK)
  ) u_ram (
    .clk    (clk),
    .wr_en  (cfg_beat),
    .wr_addr(wr_addr),
    .wr_data(cfg_data),
    .rd_addr(in_data),
    .rd_data(rd_data)
  );

  // Next-state, load address sequencing and handshake readiness.
  always_comb begin
    state_nxt        = state;
    wr_addr_nxt      = wr_addr;
    table_loaded_nxt = table_loaded;
    cfg_done_nxt     = 1'b0;
    cfg_ready        = 1'b0;
    in_ready         = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt   = LOAD;
          wr_addr_nxt = '0;
        end
      end
      LOAD: begin
        cfg_ready = !cfg_start;
        if (cfg_start) begin
          wr_addr_nxt = '0;
        end else if (cfg_valid) begin
          if (wr_addr == LAST_ADDR) begin
            state_nxt        = RUN;
            wr_addr_nxt      = '0;
            table_loaded_nxt = 1'b1;
            cfg_done_nxt     = 1'b1;
          end else begin
            wr_addr_nxt = wr_addr + STEP;
          end
        end
      end
      RUN: begin
        in_ready = table_loaded && !cfg_done && !cfg_start && (!out_valid || out_ready);
        if (cfg_start) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid) begin
          state_nxt        = LOAD;
          wr_addr_nxt      = '0;
          table_loaded_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Controller state register, load pointer and the completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_addr      <= '0;
      table_loaded <= 1'b0;
      cfg_done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_addr      <= wr_addr_nxt;
      table_loaded <= table_loaded_nxt;
      cfg_done     <= cfg_done_nxt;
    end
  end

  // One-deep result register; data is only replaced on an accepted lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (lookup) begin
      out_valid <= 1'b1;
      out_data  <= rd_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_lut_cfg_ctrl.sv
// Self-checking bench for neuron_lut_cfg_ctrl: directed scenarios plus randomized
// traffic compared against a table/queue reference model.
module tb_neuron_lut_cfg_ctrl;

  localparam int IN_BITS  = 8;
  localparam int OUT_BITS = 2;
  localparam int PACK     = 4;
  localparam int DEPTH    = 1 << IN_BITS;
  localparam int BEATS    = DEPTH / PACK;

  logic                     clk;
  logic                     rst;
  logic                     cfg_start;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [PACK*OUT_BITS-1:0] cfg_data;
  logic                     cfg_done;
  logic                     in_valid;
  logic                     in_ready;
  logic [IN_BITS-1:0]       in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_BITS-1:0]      out_data;
  logic [1:0]               ctrl_state;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [OUT_BITS-1:0]      model_table [DEPTH];
  logic [PACK*OUT_BITS-1:0] load_beats  [BEATS];
  logic [OUT_BITS-1:0]      exp_q [$];
  logic [OUT_BITS-1:0]      model_last;
  bit                       mon_en;

  neuron_lut_cfg_ctrl #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .PACK    (PACK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ctrl_state(ctrl_state)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure lookup throughput.
  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop in case a sequence stalls in a way the bounded waits miss.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the model knows how many results are pending and which value
  // each must carry, and predicts readiness from queue occupancy.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checkOutput("mon_out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) checkOutput("mon_out_data", out_data, exp_q[0]);
      else                   checkOutput("mon_out_hold", out_data, model_last);
      checkOutput("mon_in_ready", in_ready, (exp_q.size() == 0 || out_ready) && !cfg_start);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(model_table[in_data]);
        model_last = model_table[in_data];
      end
    end
  end

  task automatic doReset();
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    exp_q.delete();
    model_last = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Let pending results drain with no new lookups.
  task automatic drainOutputs();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  // Load load_beats[] into the table, optionally preceded by pre_beats junk beats
  // and a restart pulse, with optional random gaps between beats.
  task automatic loadTable(input int pre_beats, input bit gaps);
    int n;
    logic [PACK*OUT_BITS-1:0] beat;
    mon_en    = 1'b0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (n = 0; n < 8; n++) begin
      if (ctrl_state == 2'd1) break;
      step();
    end
    checkOutput("load_entry_state", ctrl_state, 2'd1);
    for (int b = 0; b < pre_beats; b++) begin
      cfg_valid = 1'b1;
      cfg_data  = 8'hFF;
      step();
    end
    if (pre_beats > 0) begin
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 8'h5A;
      @(negedge clk);
      checkOutput("restart_cfg_ready", cfg_ready, 1'b0);
      step();
      cfg_start = 1'b0;
    end
    for (int b = 0; b < BEATS; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b0;
        step();
      end
      cfg_valid = 1'b1;
      cfg_data  = load_beats[b];
      @(negedge clk);
      checkOutput("load_cfg_ready", cfg_ready, 1'b1);
      checkOutput("load_cfg_done_low", cfg_done, 1'b0);
      checkOutput("load_state", ctrl_state, 2'd1);
      step();
    end
    cfg_valid = 1'b0;
    checkOutput("done_pulse", cfg_done, 1'b1);
    checkOutput("done_state_run", ctrl_state, 2'd3);
    checkOutput("done_in_ready_low", in_ready, 1'b0);
    step();
    checkOutput("done_pulse_end", cfg_done, 1'b0);
    checkOutput("after_done_in_ready", in_ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      beat = load_beats[i / PACK];
      model_table[i] = beat[(i % PACK)*OUT_BITS +: OUT_BITS];
    end
    mon_en = 1'b1;
  endtask

  // Present one lookup and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [IN_BITS-1:0] addr);
    int n;
    in_valid = 1'b1;
    in_data  = addr;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) checkOutput("accept_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int start_cyc;
    logic [IN_BITS-1:0] probe;

    doReset();

    // Idle after reset: lookups are refused and nothing is produced.
    checkOutput("reset_out_data", out_data, 2'b00);
    checkOutput("reset_cfg_done", cfg_done, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("idle_state", ctrl_state, 2'd0);
      checkOutput("idle_in_ready", in_ready, 1'b0);
      checkOutput("idle_out_valid", out_valid, 1'b0);
      checkOutput("idle_cfg_ready", cfg_ready, 1'b0);
      step();
    end
    in_valid = 1'b0;

    // Pattern table: entry i = i[1:0].
    for (int b = 0; b < BEATS; b++) load_beats[b] = 8'b11100100;
    loadTable(0, 1'b0);
    out_ready = 1'b1;
    applyStimulus(8'h37);
    checkOutput("lookup_37_valid", out_valid, 1'b1);
    checkOutput("lookup_37_data", out_data, 2'b11);
    applyStimulus(8'h02);
    checkOutput("lookup_02_data", out_data, 2'b10);
    drainOutputs();

    // Back-to-back lookups at full rate.
    start_cyc = cycle;
    applyStimulus(8'h01);
    checkOutput("b2b_01", out_data, 2'b01);
    applyStimulus(8'h02);
    checkOutput("b2b_02", out_data, 2'b10);
    applyStimulus(8'h03);
    checkOutput("b2b_03", out_data, 2'b11);
    checkOutput("b2b_cycles", cycle - start_cyc, 3);
    drainOutputs();

    // Backpressure: result held, input refused, then stream resumes in order.
    applyStimulus(8'h01);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h02;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", in_ready, 1'b0);
      checkOutput("stall_out_data", out_data, 2'b01);
      step();
    end
    out_ready = 1'b1;
    applyStimulus(8'h02);
    checkOutput("resume_02", out_data, 2'b10);
    applyStimulus(8'h03);
    checkOutput("resume_03", out_data, 2'b11);
    drainOutputs();

    // Restart mid-load, then an all-zero table.
    for (int b = 0; b < BEATS; b++) load_beats[b] = 8'h00;
    loadTable(10, 1'b0);
    applyStimulus(8'hFF);
    checkOutput("restart_lookup_ff", out_data, 2'b00);
    drainOutputs();

    // Randomized table load with gaps, then random traffic.
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < BEATS; b++) load_beats[b] = 8'($urandom);
      loadTable(0, 1'b1);
      for (int c = 0; c < 300; c++) begin
        in_valid  = $urandom_range(0, 1) == 1;
        in_data   = 8'($urandom);
        out_ready = $urandom_range(0, 3) != 0;
        step();
      end
      drainOutputs();
    end

    // Drain sequencing and asynchronous reset mid-load.
    probe = 8'h05;
    for (int i = 0; i < DEPTH; i++) begin
      if (model_table[i] != 2'b00) begin
        probe = 8'(i);
        break;
      end
    end
    out_ready = 1'b0;
    applyStimulus(probe);
    checkOutput("drain_pending_data", out_data, model_table[probe]);
    mon_en    = 1'b0;
    cfg_start = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    checkOutput("drain_start_in_ready", in_ready, 1'b0);
    step();
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    checkOutput("drain_state", ctrl_state, 2'd2);
    checkOutput("drain_in_ready", in_ready, 1'b0);
    checkOutput("drain_out_valid", out_valid, 1'b1);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    checkOutput("drain_extra_start", ctrl_state, 2'd2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("drain_consumed", out_valid, 1'b0);
    for (int n = 0; n < 4; n++) begin
      if (ctrl_state == 2'd1) break;
      step();
    end
    checkOutput("drain_to_load", ctrl_state, 2'd1);
    cfg_valid = 1'b1;
    cfg_data  = 8'hC3;
    repeat (2) step();
    checkOutput("midload_out_data", out_data, model_table[probe]);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_state", ctrl_state, 2'd0);
    checkOutput("async_cfg_ready", cfg_ready, 1'b0);
    checkOutput("async_cfg_done", cfg_done, 1'b0);
    checkOutput("async_in_ready", in_ready, 1'b0);
    checkOutput("async_out_valid", out_valid, 1'b0);
    checkOutput("async_out_data", out_data, 2'b00);
    doReset();
    @(negedge clk);
    checkOutput("post_reset_state", ctrl_state, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_lut_cfg_ctrl.md
Name: neuron_lut_cfg_ctrl

Overview:
Runtime-programmable neuron truth-table controller. It replaces a fixed distributed-ROM neuron with a distributed-RAM table, loads the table from a packed configuration stream, then serves inference lookups through a valid/ready pipeline stage. It sits between the layer's config/DMA path and the layer's registered neuron datapath, and sequences loading versus lookup so the two never collide.

Parameters:
IN_BITS, 8, neuron input width; table depth DEPTH = 2**IN_BITS.
OUT_BITS, 2, neuron output width, i.e. one table entry.
PACK, 4, table entries per config beat; DEPTH % PACK == 0 is required and is checked at elaboration.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset.
cfg_start  in  1  single-cycle pulse that requests a (re)load of the table.
cfg_valid  in  1  config beat valid.
cfg_ready  out  1  config beat accepted; asserted only in LOAD.
cfg_data  in  PACK*OUT_BITS  packed entries; entry k is cfg_data[k*OUT_BITS +: OUT_BITS].
cfg_done  out  1  one-cycle pulse when a table load completes.
in_valid  in  1  lookup request valid.
in_ready  out  1  lookup accepted.
in_data  in  IN_BITS  table address (the neuron input vector).
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  OUT_BITS  table entry.
ctrl_state  out  2  current state: IDLE=0, LOAD=1, DRAIN=2, RUN=3.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, wr_addr=0, table_loaded=0.
  - cfg_ready=0, cfg_done=0, in_ready=0, out_valid=0, out_data=0.
  - Table RAM is not reset, but table_loaded=0 forces a reload before any lookup.
- IDLE:
  - in_ready=0, cfg_ready=0.
  - cfg_start -> LOAD next cycle, with wr_addr=0.
- LOAD:
  - cfg_ready=1; in_ready=0.
  - Each cfg_valid&&cfg_ready beat writes entries wr_addr..wr_addr+PACK-1 (synchronous write), then wr_addr += PACK.
  - Gaps in cfg_valid are legal; wr_addr holds across them.
  - Beat accepted with wr_addr==DEPTH-PACK:
    - next state RUN, table_loaded=1, wr_addr wraps to 0;
    - cfg_done=1 for exactly the following cycle.
  - cfg_start while in LOAD: wr_addr resets to 0; any beat in that same cycle is discarded (cfg_ready=0 that cycle). The load restarts from entry 0.
- RUN:
  - in_ready = !out_valid || out_ready (one-deep output register, full throughput).
  - An in_valid&&in_ready handshake registers out_data=table[in_data] and out_valid=1 on the next edge. Latency is 1 cycle.
  - out_valid clears when out_ready=1 and no new handshake occurs in that cycle.
  - cfg_start -> DRAIN. In the cfg_start cycle in_ready is forced to 0, so no lookup is accepted.
- DRAIN:
  - in_ready=0, cfg_ready=0.
  - Stays in DRAIN while out_valid=1.
  - When out_valid=0 (pending result consumed) -> LOAD with wr_addr=0 and table_loaded=0.
  - Extra cfg_start pulses are ignored.
- No lookup ever reads a partially written table.
- cfg_done never coincides with in_ready=1: in_ready first rises the cycle after cfg_done, together with it.
- out_data holds its value while out_valid=0.
- rst asserted mid-LOAD or mid-DRAIN: immediate return to IDLE; the partial load is abandoned.

Decomposition:
- Package neuron_lut_cfg_pkg:
  - state enum {IDLE, LOAD, DRAIN, RUN} with the encodings above;
  - function for DEPTH;
  - function for CFG_W = PACK*OUT_BITS.
- Sub-module neuron_lut_ram: DEPTH x OUT_BITS distributed RAM with rom_style/ram_style "distributed", PACK-wide synchronous write port and asynchronous read.
- The controller holds the FSM, wr_addr counter and output register.

Test Plan:
1. Reset, then in_valid=1, in_data=8'h00 for 5 cycles -> ctrl_state=0, in_ready=0, out_valid=0, cfg_ready=0 throughout.
2. cfg_start, then 64 beats of cfg_data=8'b11100100, so entry i = i[1:0]:
   - cfg_done is high exactly one cycle after beat 64 and ctrl_state=3;
   - then in_data=8'h37 -> out_data=2'b11, out_valid=1 on the next cycle;
   - then in_data=8'h02 -> 2'b10.
3. Back-to-back lookups 8'h01, 8'h02, 8'h03 with out_ready=1 -> one result per cycle: 01, 10, 11.
4. Same inputs with out_ready=0 from cycle 2 -> in_ready=0 and out_data held at 2'b01; after out_ready=1, results continue in order with no loss or duplication.
5. Restart mid-load:
   - cfg_start, 10 beats, then cfg_start again, then 64 beats of 8'h00;
   - cfg_done only after the 64th post-restart beat;
   - lookup 8'hFF -> 2'b00.
6. Drain and async reset:
   - In RUN with out_valid=1 and out_ready=0, pulse cfg_start -> ctrl_state=2, in_ready=0;
   - out_ready=1 for one cycle -> ctrl_state=1;
   - assert rst mid-load (not clock-aligned) -> all outputs 0 and ctrl_state=0 before the next clock edge.
